// File: rtl/quad_decoder_if.sv
// rtl/quad_decoder_if.sv - encoder channel inputs and step/error outputs of quad_decoder
interface quad_decoder_if;
  logic i_a_in;
  logic i_b_in;
  logic i_err_clr;
  logic o_up;
  logic o_down;
  logic o_err;
  logic o_err_flag;

  modport master (
    output i_a_in, i_b_in, i_err_clr,
    input  o_up, o_down, o_err, o_err_flag
  );

  modport slave (
    input  i_a_in, i_b_in, i_err_clr,
    output o_up, o_down, o_err, o_err_flag
  );
endinterface

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature front end: sync, deglitch, decode to up/down/err pulses
// Define QUAD_DECODER_X4_EN for x4 decoding; otherwise x1 (01->00 up, 00->01 down).
module quad_decoder #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input logic          clk,
  input logic          rst,
  quad_decoder_if.slave bus
);

  localparam int FW       = $clog2(FILTER_CYCLES + 1);
  localparam int SETTLE_N = SYNC_STAGES + FILTER_CYCLES;
  localparam int SW       = $clog2(SETTLE_N + 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_N);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  logic [SYNC_STAGES-1:0] r_a_sync;
  logic [SYNC_STAGES-1:0] r_b_sync;
  logic [1:0]             w_s;
  logic [1:0]             r_f;
  logic [FW-1:0]          r_fcnt [2];
  logic [1:0]             r_prev;
  logic [SW-1:0]          r_settle;
  state_t                 r_state;
  logic                   r_up;
  logic                   r_down;
  logic                   r_err;
  logic                   r_err_flag;
  logic                   w_up;
  logic                   w_down;
  logic                   w_both;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sync <= '0;
      r_b_sync <= '0;
    end else begin
      r_a_sync <= {r_a_sync[SYNC_STAGES-2:0], bus.i_a_in};
      r_b_sync <= {r_b_sync[SYNC_STAGES-2:0], bus.i_b_in};
    end
  end

  assign w_s = {r_a_sync[SYNC_STAGES-1], r_b_sync[SYNC_STAGES-1]};

  // Bit 1 is channel A, bit 0 is channel B, so r_f reads as {a_f, b_f}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f       <= '0;
      r_fcnt[0] <= '0;
      r_fcnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_s[i] == r_f[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FCNT_LAST) begin
          r_f[i]    <= w_s[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_both = &(r_prev ^ r_f);

`ifdef QUAD_DECODER_X4_EN
  always_comb begin
    w_up   = 1'b0;
    w_down = 1'b0;
    case ({r_prev, r_f})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_up   = 1'b1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_down = 1'b1;
      default: ;
    endcase
  end
`else
  assign w_up   = ({r_prev, r_f} == 4'b01_00);
  assign w_down = ({r_prev, r_f} == 4'b00_01);
`endif

  // The settle count runs one past SETTLE_N so the filters have caught the
  // static position before prev is loaded; a resting 11 then decodes as no-op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_settle   <= '0;
      r_prev     <= '0;
      r_up       <= 1'b0;
      r_down     <= 1'b0;
      r_err      <= 1'b0;
      r_err_flag <= 1'b0;
    end else begin
      r_up   <= 1'b0;
      r_down <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_INIT: begin
          if (r_settle == SETTLE_LAST) begin
            r_prev  <= r_f;
            r_state <= ST_RUN;
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        ST_RUN: begin
          r_prev <= r_f;
          r_up   <= w_up & ~w_both;
          r_down <= w_down & ~w_both;
          r_err  <= w_both;
        end
        default: r_state <= ST_INIT;
      endcase
      // Set wins over clear both on the detecting edge and while err is high.
      if (((r_state == ST_RUN) && w_both) || r_err)
        r_err_flag <= 1'b1;
      else if (bus.i_err_clr)
        r_err_flag <= 1'b0;
    end
  end

  assign bus.o_up       = r_up;
  assign bus.o_down     = r_down;
  assign bus.o_err      = r_err;
  assign bus.o_err_flag = r_err_flag;

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - directed self-checking bench for quad_decoder (x1 or x4 build)
module tb_quad_decoder;

`ifdef QUAD_DECODER_X4_EN
  localparam bit X4 = 1'b1;
`else
  localparam bit X4 = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;
  int          n_up = 0;
  int          n_down = 0;
  int          n_err = 0;
  logic [15:0] cnt16 = 16'd0;

  quad_decoder_if bus();

  quad_decoder #(.SYNC_STAGES(2), .FILTER_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pulses();
    return {29'd0, bus.o_up, bus.o_down, bus.o_err};
  endfunction

  // Input changes just after an edge; the pulse must appear after the 7th edge only.
  task automatic step(input string tag, input logic a, input logic b,
                      input logic eu, input logic ed, input logic ee);
    bus.i_a_in = a;
    bus.i_b_in = b;
    tick(6);
    check({tag, "_pre"}, pulses(), 32'd0);
    tick(1);
    check({tag, "_pulse"}, pulses(), {29'd0, eu, ed, ee});
    tick(1);
    check({tag, "_post"}, pulses(), 32'd0);
    tick(2);
  endtask

  // Step counter standing in for the downstream count block.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_up) begin
        n_up++;
        cnt16 = cnt16 + 16'd1;
      end
      if (bus.o_down) begin
        n_down++;
        cnt16 = cnt16 - 16'd1;
      end
      if (bus.o_err) n_err++;
      if (bus.o_up || bus.o_down) begin
        checks++;
        assert (!(bus.o_up && bus.o_down)) else begin
          errors++;
          $error("FAIL up_down_excl observed=11 expected=not both");
        end
      end
    end
  end

  initial begin
    int bu, bd, be;
    logic [15:0] base, diff;

    rst = 1'b1;
    bus.i_a_in = 1'b0;
    bus.i_b_in = 1'b0;
    bus.i_err_clr = 1'b0;
    tick(2);
    check("reset_outputs", {28'd0, bus.o_up, bus.o_down, bus.o_err, bus.o_err_flag}, 32'd0);

    rst = 1'b0;
    bu = n_up; bd = n_down; be = n_err;
    tick(20);
    check("init_quiet", n_up - bu + n_down - bd + n_err - be, 32'd0);

    step("fwd_10", 1'b1, 1'b0, X4, 1'b0, 1'b0);
    step("fwd_11", 1'b1, 1'b1, X4, 1'b0, 1'b0);
    step("fwd_01", 1'b0, 1'b1, X4, 1'b0, 1'b0);
    step("fwd_00", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    step("rev_01", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step("rev_11", 1'b1, 1'b1, 1'b0, X4, 1'b0);
    step("rev_10", 1'b1, 1'b0, 1'b0, X4, 1'b0);
    step("rev_00", 1'b0, 1'b0, 1'b0, X4, 1'b0);

    bu = n_up; bd = n_down; be = n_err;
    bus.i_a_in = 1'b1;
    tick(3);
    bus.i_a_in = 1'b0;
    tick(15);
    check("glitch3_up", n_up - bu, 32'd0);
    check("glitch3_down", n_down - bd, 32'd0);
    check("glitch3_err", n_err - be, 32'd0);

    bu = n_up; bd = n_down; be = n_err;
    bus.i_a_in = 1'b1;
    tick(4);
    bus.i_a_in = 1'b0;
    tick(20);
    check("glitch4_up", n_up - bu, {31'd0, X4});
    check("glitch4_down", n_down - bd, {31'd0, X4});
    check("glitch4_err", n_err - be, 32'd0);

    step("illegal_00_11", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("err_flag_set", {31'd0, bus.o_err_flag}, 32'd1);
    tick(20);
    check("err_flag_hold", {31'd0, bus.o_err_flag}, 32'd1);
    bus.i_err_clr = 1'b1;
    tick(1);
    bus.i_err_clr = 1'b0;
    check("err_flag_clr", {31'd0, bus.o_err_flag}, 32'd0);

    bus.i_a_in = 1'b0;
    bus.i_b_in = 1'b0;
    tick(6);
    bus.i_err_clr = 1'b1;
    tick(1);
    check("clr_vs_err_pulse", {30'd0, bus.o_err, bus.o_err_flag}, 32'd3);
    tick(1);
    bus.i_err_clr = 1'b0;
    check("clr_vs_err_flag", {31'd0, bus.o_err_flag}, 32'd1);
    tick(1);
    check("clr_vs_err_hold", {31'd0, bus.o_err_flag}, 32'd1);
    bus.i_err_clr = 1'b1;
    tick(1);
    bus.i_err_clr = 1'b0;
    check("err_flag_clr2", {31'd0, bus.o_err_flag}, 32'd0);

    bus.i_a_in = 1'b1;
    bus.i_b_in = 1'b1;
    tick(7);
    check("mid_err_pulse", {30'd0, bus.o_err, bus.o_err_flag}, 32'd3);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_outputs", {28'd0, bus.o_up, bus.o_down, bus.o_err, bus.o_err_flag}, 32'd0);
    #2;
    rst = 1'b0;
    bu = n_up; bd = n_down; be = n_err;
    tick(20);
    check("post_rst_quiet", n_up - bu + n_down - bd + n_err - be, 32'd0);
    check("post_rst_flag", {31'd0, bus.o_err_flag}, 32'd0);
    step("post_rst_11_01", 1'b0, 1'b1, X4, 1'b0, 1'b0);
    step("post_rst_01_00", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    base = cnt16;
    be = n_err;
    for (int c = 0; c < 1000; c++) begin
      bus.i_a_in = 1'b1; bus.i_b_in = 1'b0; tick(5);
      bus.i_a_in = 1'b1; bus.i_b_in = 1'b1; tick(5);
      bus.i_a_in = 1'b0; bus.i_b_in = 1'b1; tick(5);
      bus.i_a_in = 1'b0; bus.i_b_in = 1'b0; tick(5);
    end
    for (int c = 0; c < 250; c++) begin
      bus.i_a_in = 1'b0; bus.i_b_in = 1'b1; tick(5);
      bus.i_a_in = 1'b1; bus.i_b_in = 1'b1; tick(5);
      bus.i_a_in = 1'b1; bus.i_b_in = 1'b0; tick(5);
      bus.i_a_in = 1'b0; bus.i_b_in = 1'b0; tick(5);
    end
    tick(12);
    diff = cnt16 - base;
    check("chain_count", {16'd0, diff}, X4 ? 32'd3000 : 32'd750);
    check("chain_err", n_err - be, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
